// File: rtl/sdpb_stream_fifo.sv
// Synchronous FWFT stream FIFO over simple dual-port block RAM with a two-entry
// prefetch (RAM read register + output register), level flags and optional overwrite-oldest.
module sdpb_stream_fifo #(
  parameter int ADDRESS_DEPTH       = 512,
  parameter int DATA_WIDTH          = 32,
  parameter int ALMOST_FULL_THRESH  = ADDRESS_DEPTH - 4,
  parameter int ALMOST_EMPTY_THRESH = 4,
  parameter bit OVERWRITE_MODE      = 1'b0
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 flush,
  input  logic                                 s_valid,
  input  logic [DATA_WIDTH-1:0]                s_data,
  output logic                                 s_ready,
  output logic                                 m_valid,
  output logic [DATA_WIDTH-1:0]                m_data,
  input  logic                                 m_ready,
  output logic [$clog2(ADDRESS_DEPTH):0]       level,
  output logic                                 full,
  output logic                                 empty,
  output logic                                 almost_full,
  output logic                                 almost_empty,
  output logic                                 drop
);

  localparam int AW = $clog2(ADDRESS_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(ADDRESS_DEPTH);
  localparam logic [LW-1:0] AF_L    = LW'(ALMOST_FULL_THRESH);
  localparam logic [LW-1:0] AE_L    = LW'(ALMOST_EMPTY_THRESH);

  logic [DATA_WIDTH-1:0] mem [ADDRESS_DEPTH];

  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [LW-1:0]         level_r;
  logic [LW-1:0]         ram_cnt;
  logic                  drop_r;

  logic [DATA_WIDTH-1:0] data_p1;
  logic                  vld_p1;
  logic [DATA_WIDTH-1:0] data_p2;
  logic                  vld_p2;

  logic                  full_w;
  logic                  wr_fire;
  logic                  rd_fire;
  logic                  discard;
  logic                  load_p2;
  logic                  issue;

  always_comb begin
    full_w  = (level_r == DEPTH_L);
    s_ready = !rst && !flush && (!full_w || OVERWRITE_MODE);
    wr_fire = s_valid && s_ready;
    rd_fire = vld_p2 && m_ready;
    // Full with no read leaving: make room by dropping the oldest word still in RAM.
    discard = OVERWRITE_MODE && wr_fire && full_w && !rd_fire;
    load_p2 = vld_p1 && (!vld_p2 || m_ready);
    issue   = (ram_cnt != '0) && (!vld_p1 || load_p2);
  end

  // Stage p0 -> p1: RAM write port and registered read port
  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_ptr] <= s_data;
    if (issue)   data_p1     <= mem[rd_ptr];
  end

  // Pointer, occupancy and p1 -> p2 output stage control
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_r <= '0;
      ram_cnt <= '0;
      vld_p1  <= 1'b0;
      vld_p2  <= 1'b0;
      data_p2 <= '0;
      drop_r  <= 1'b0;
    end else begin
      if (wr_fire) wr_ptr <= wr_ptr + 1'b1;
      rd_ptr  <= rd_ptr + AW'(issue) + AW'(discard);
      ram_cnt <= ram_cnt + LW'(wr_fire) - LW'(issue) - LW'(discard);

      if (wr_fire && !rd_fire && !full_w)
        level_r <= level_r + 1'b1;
      else if (!wr_fire && rd_fire)
        level_r <= level_r - 1'b1;

      vld_p1 <= issue || (vld_p1 && !load_p2);

      if (load_p2) begin
        vld_p2  <= 1'b1;
        data_p2 <= data_p1;
      end else if (rd_fire) begin
        vld_p2  <= 1'b0;
      end

      drop_r <= discard;
    end
  end

  assign m_valid      = vld_p2;
  assign m_data       = data_p2;
  assign level        = level_r;
  assign full         = full_w;
  assign empty        = (level_r == '0);
  assign almost_full  = (level_r >= AF_L);
  assign almost_empty = (level_r <= AE_L);
  assign drop         = drop_r;

endmodule

// File: tb/tb_sdpb_stream_fifo.sv
// Bench for sdpb_stream_fifo: vector table, directed corner sequences and a random
// stream checked against a queue model of the 512-deep FIFO, plus an 8-deep overwrite instance.
module tb_sdpb_stream_fifo;

  localparam int DEPTH = 512;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        s_valid = 1'b0;
  logic [31:0] s_data = '0;
  logic        s_ready;
  logic        m_valid;
  logic [31:0] m_data;
  logic        m_ready = 1'b0;
  logic [9:0]  level;
  logic        full, empty, almost_full, almost_empty, drop;

  logic        ov_flush = 1'b0;
  logic        ov_s_valid = 1'b0;
  logic [31:0] ov_s_data = '0;
  logic        ov_s_ready;
  logic        ov_m_valid;
  logic [31:0] ov_m_data;
  logic        ov_m_ready = 1'b0;
  logic [3:0]  ov_level;
  logic        ov_full, ov_empty, ov_almost_full, ov_almost_empty, ov_drop;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sdpb_stream_fifo #(.ADDRESS_DEPTH(DEPTH), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .level(level), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .drop(drop)
  );

  sdpb_stream_fifo #(.ADDRESS_DEPTH(8), .DATA_WIDTH(32), .ALMOST_FULL_THRESH(6),
                     .ALMOST_EMPTY_THRESH(2), .OVERWRITE_MODE(1'b1)) dut_ov (
    .clk(clk), .rst(rst), .flush(ov_flush),
    .s_valid(ov_s_valid), .s_data(ov_s_data), .s_ready(ov_s_ready),
    .m_valid(ov_m_valid), .m_data(ov_m_data), .m_ready(ov_m_ready),
    .level(ov_level), .full(ov_full), .empty(ov_empty),
    .almost_full(ov_almost_full), .almost_empty(ov_almost_empty), .drop(ov_drop)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: an ordered queue of accepted-but-undelivered words.
  logic [31:0] q[$];
  bit          mon_en = 1'b0;
  bit          hold_prev = 1'b0;
  logic [31:0] hold_data = '0;

  always @(negedge clk) begin
    if (mon_en) begin
      logic exp_sr;
      check("level", level, q.size());
      check("empty", empty, q.size() == 0);
      check("full", full, q.size() == DEPTH);
      check("almost_full", almost_full, q.size() >= DEPTH - 4);
      check("almost_empty", almost_empty, q.size() <= 4);
      check("drop", drop, 1'b0);
      exp_sr = !rst && !flush && (q.size() < DEPTH);
      check("s_ready", s_ready, exp_sr);
      if (hold_prev) begin
        check("hold_valid", m_valid, 1'b1);
        check("hold_data", m_data, hold_data);
      end
      hold_prev = m_valid && !m_ready && !rst && !flush;
      hold_data = m_data;
      if (rst || flush) begin
        q.delete();
      end else begin
        if (m_valid && m_ready) begin
          if (q.size() == 0) check("valid_with_no_data", m_valid, 1'b0);
          else               check("order", m_data, q.pop_front());
        end
        if (s_valid && exp_sr) q.push_back(s_data);
      end
    end
  end

  typedef struct {
    logic        rst;
    logic        sv;
    logic [31:0] sd;
    logic        ev;
    logic [31:0] ed;
    logic        cd;
    logic [9:0]  el;
    logic        ee;
    logic        esr;
  } vec_t;

  vec_t vt[8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got[$];
    int present;
    bit incr;

    // First-word latency and back-to-back delivery after reset, m_ready held high.
    vt[0] = '{1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 10'd0, 1'b1, 1'b0};
    vt[1] = '{1'b0, 1'b1, 32'd1, 1'b0, 32'd0, 1'b0, 10'd1, 1'b0, 1'b1};
    vt[2] = '{1'b0, 1'b1, 32'd2, 1'b0, 32'd0, 1'b0, 10'd2, 1'b0, 1'b1};
    vt[3] = '{1'b0, 1'b1, 32'd3, 1'b1, 32'd1, 1'b1, 10'd3, 1'b0, 1'b1};
    vt[4] = '{1'b0, 1'b1, 32'd4, 1'b1, 32'd2, 1'b1, 10'd3, 1'b0, 1'b1};
    vt[5] = '{1'b0, 1'b0, 32'd0, 1'b1, 32'd3, 1'b1, 10'd2, 1'b0, 1'b1};
    vt[6] = '{1'b0, 1'b0, 32'd0, 1'b1, 32'd4, 1'b1, 10'd1, 1'b0, 1'b1};
    vt[7] = '{1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 10'd0, 1'b1, 1'b1};
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rst = vt[i].rst; s_valid = vt[i].sv; s_data = vt[i].sd;
      tick();
      check($sformatf("vec%0d_m_valid", i), m_valid, vt[i].ev);
      if (vt[i].cd) check($sformatf("vec%0d_m_data", i), m_data, vt[i].ed);
      check($sformatf("vec%0d_level", i), level, vt[i].el);
      check($sformatf("vec%0d_empty", i), empty, vt[i].ee);
      check($sformatf("vec%0d_s_ready", i), s_ready, vt[i].esr);
      if (i == 0) mon_en = 1'b1;
    end

    // Fill to capacity with the consumer stalled; pointers start mid-array so the drain wraps.
    m_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      s_valid = 1'b1; s_data = i;
      tick();
      if (i == 506) check("af_at_507", almost_full, 1'b0);
      if (i == 507) check("af_at_508", almost_full, 1'b1);
    end
    check("fill_level", level, DEPTH);
    check("fill_full", full, 1'b1);
    check("fill_s_ready", s_ready, 1'b0);
    s_data = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) tick();
    check("extra_write_ignored", level, DEPTH);

    // Full, both sides active: first edge only reads, then one in and one out per cycle.
    m_ready = 1'b1;
    for (int k = 0; k < 100; k++) begin
      s_data = DEPTH + k;
      check("stream_m_valid", m_valid, 1'b1);
      tick();
      check("stream_level", level, DEPTH - 1);
    end
    s_valid = 1'b0;
    for (int i = 0; i < 700 && !empty; i++) tick();
    check("drain_empty", empty, 1'b1);

    // Stall with writes continuing: presented word must not move.
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin s_valid = 1'b1; s_data = 32'h500 + i; tick(); end
    for (int i = 0; i < 10; i++) begin
      s_data = 32'h600 + i;
      tick();
      check("stall_m_data", m_data, 32'h500);
    end
    s_valid = 1'b0; m_ready = 1'b1;
    for (int i = 0; i < 40 && !empty; i++) tick();
    check("stall_drain_empty", empty, 1'b1);

    // Flush mid-stream with a write offered on the flush edge.
    m_ready = 1'b0;
    for (int i = 0; i < 37; i++) begin s_valid = 1'b1; s_data = 32'h100 + i; tick(); end
    check("pre_flush_level", level, 37);
    flush = 1'b1; s_data = 32'h1234;
    tick();
    check("flush_level", level, 0);
    check("flush_m_valid", m_valid, 1'b0);
    check("flush_empty", empty, 1'b1);
    flush = 1'b0; s_valid = 1'b1; s_data = 32'hA5A5A5A5; m_ready = 1'b1;
    tick();
    s_valid = 1'b0;
    check("post_flush_e0", m_valid, 1'b0);
    tick();
    check("post_flush_e1", m_valid, 1'b0);
    tick();
    check("post_flush_e2_valid", m_valid, 1'b1);
    check("post_flush_e2_data", m_data, 32'hA5A5A5A5);
    tick();

    // Random traffic with occasional flushes.
    for (int i = 0; i < 3000; i++) begin
      s_valid = ($urandom_range(0, 9) < 7);
      s_data  = $urandom;
      m_ready = ($urandom_range(0, 9) < 6);
      flush   = ($urandom_range(0, 299) == 0);
      tick();
    end
    flush = 1'b0; s_valid = 1'b0; m_ready = 1'b1;
    for (int i = 0; i < 700 && !empty; i++) tick();
    check("random_drain_empty", empty, 1'b1);

    // Overwrite-oldest on the 8-deep instance.
    rst = 1'b1; tick(); rst = 1'b0;
    ov_m_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin ov_s_valid = 1'b1; ov_s_data = i; tick(); end
    check("ov_fill_level", ov_level, 8);
    check("ov_fill_full", ov_full, 1'b1);
    check("ov_s_ready_full", ov_s_ready, 1'b1);
    for (int i = 8; i < 10; i++) begin
      ov_s_data = i;
      tick();
      check("ov_drop", ov_drop, 1'b1);
      check("ov_level", ov_level, 8);
      check("ov_m_data_kept", ov_m_data, 0);
    end
    ov_s_valid = 1'b0;
    tick();
    check("ov_drop_clear", ov_drop, 1'b0);
    ov_m_ready = 1'b1;
    got.delete();
    for (int i = 0; i < 40 && !(ov_empty && !ov_m_valid); i++) begin
      if (ov_m_valid) got.push_back(ov_m_data);
      tick();
    end
    check("ov_count", got.size(), 8);
    if (got.size() == 8) begin
      check("ov_first", got[0], 0);
      check("ov_last_m1", got[6], 8);
      check("ov_last", got[7], 9);
      present = 0; incr = 1'b1;
      for (int i = 0; i < 8; i++) begin
        if (got[i] >= 1 && got[i] <= 7) present++;
        if (i > 0 && got[i] <= got[i-1]) incr = 1'b0;
      end
      check("ov_survivors_1to7", present, 5);
      check("ov_increasing", incr, 1'b1);
    end

    // Overwrite instance full with reads and writes each cycle: no drop, no loss.
    ov_m_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin ov_s_valid = 1'b1; ov_s_data = 100 + i; tick(); end
    ov_m_ready = 1'b1;
    got.delete();
    for (int k = 0; k < 100; k++) begin
      ov_s_data = 108 + k;
      check("ovs_m_valid", ov_m_valid, 1'b1);
      check("ovs_s_ready", ov_s_ready, 1'b1);
      if (ov_m_valid) got.push_back(ov_m_data);
      tick();
      check("ovs_level", ov_level, 8);
      check("ovs_drop", ov_drop, 1'b0);
    end
    ov_s_valid = 1'b0;
    for (int i = 0; i < 40 && !(ov_empty && !ov_m_valid); i++) begin
      if (ov_m_valid) got.push_back(ov_m_data);
      tick();
    end
    check("ovs_count", got.size(), 108);
    for (int i = 0; i < got.size() && i < 108; i++) check("ovs_order", got[i], 100 + i);

    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
